// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction port, data port and SRAM port signals shared by
// the arbiter (slave view) and its clients plus SRAM (master view).
interface mem_port_arbiter_if #(
  parameter int AW = 14
);
  logic          im_req;
  logic [AW+1:0] im_addr;
  logic          im_flush;
  logic          dm_req;
  logic [3:0]    dm_web;
  logic [AW+1:0] dm_addr;
  logic [31:0]   dm_wdata;

  logic          im_gnt;
  logic          dm_gnt;
  logic          im_stall;
  logic          dm_stall;
  logic          im_rvalid;
  logic          dm_rvalid;
  logic [31:0]   im_rdata;
  logic [31:0]   dm_rdata;

  logic          mem_cs;
  logic          mem_oe;
  logic [3:0]    mem_web;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_di;
  logic [31:0]   mem_do;

  modport slave (
    input  im_req, im_addr, im_flush, dm_req, dm_web, dm_addr, dm_wdata, mem_do,
    output im_gnt, dm_gnt, im_stall, dm_stall, im_rvalid, dm_rvalid,
           im_rdata, dm_rdata, mem_cs, mem_oe, mem_web, mem_a, mem_di
  );

  modport master (
    output im_req, im_addr, im_flush, dm_req, dm_web, dm_addr, dm_wdata, mem_do,
    input  im_gnt, dm_gnt, im_stall, dm_stall, im_rvalid, dm_rvalid,
           im_rdata, dm_rdata, mem_cs, mem_oe, mem_web, mem_a, mem_di
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction and data masters: DM wins by
// default, IM is forced through after STARVE_LIMIT consecutive denied cycles.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int AW           = 14
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IM = 2'd1,
    RD_DM = 2'd2
  } state_t;

  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

  state_t        state_reg, state_next;
  logic [1:0]    starve_cnt_reg, starve_cnt_next;
  logic [31:0]   im_hold_reg, dm_hold_reg;

  logic          starved;
  logic          im_gnt, dm_gnt;
  logic          dm_read;
  logic          im_rvalid, dm_rvalid;
  logic          mem_cs, mem_oe;
  logic [3:0]    mem_web;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_di;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.im_addr[1:0], bus.dm_addr[1:0]};

  // Grants are gated by rst so the SRAM port stays idle while reset is held.
  always_comb begin
    starved = (starve_cnt_reg == STARVE_MAX);
    im_gnt  = ~rst & bus.im_req & (~bus.dm_req | starved);
    dm_gnt  = ~rst & bus.dm_req & ~im_gnt;
    dm_read = (bus.dm_web == 4'hF);
  end

  always_comb begin
    starve_cnt_next = 2'd0;
    if (bus.im_req && !im_gnt) begin
      starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 2'd1;
    end
  end

  always_comb begin
    mem_cs  = 1'b0;
    mem_oe  = 1'b0;
    mem_web = 4'hF;
    mem_a   = '0;
    mem_di  = '0;
    if (im_gnt) begin
      mem_cs = 1'b1;
      mem_oe = 1'b1;
      mem_a  = bus.im_addr[AW+1:2];
      mem_di = bus.dm_wdata;
    end else if (dm_gnt) begin
      mem_cs  = 1'b1;
      mem_oe  = dm_read;
      mem_web = bus.dm_web;
      mem_a   = bus.dm_addr[AW+1:2];
      mem_di  = bus.dm_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The state only tracks which read returns next cycle; a new grant may be
  // issued in any state, so reads can stream at one per cycle.
  always_comb begin
    state_next = IDLE;
    im_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    if (im_gnt) begin
      state_next = RD_IM;
    end else if (dm_gnt && dm_read) begin
      state_next = RD_DM;
    end
    case (state_reg)
      RD_IM:   im_rvalid = ~bus.im_flush;
      RD_DM:   dm_rvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= 2'd0;
      im_hold_reg    <= '0;
      dm_hold_reg    <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (im_rvalid) begin
        im_hold_reg <= bus.mem_do;
      end
      if (dm_rvalid) begin
        dm_hold_reg <= bus.mem_do;
      end
    end
  end

  assign bus.im_gnt    = im_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.im_stall  = bus.im_req & ~im_gnt;
  assign bus.dm_stall  = bus.dm_req & ~dm_gnt;
  assign bus.im_rvalid = im_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.im_rdata  = im_rvalid ? bus.mem_do : im_hold_reg;
  assign bus.dm_rdata  = dm_rvalid ? bus.mem_do : dm_hold_reg;
  assign bus.mem_cs    = mem_cs;
  assign bus.mem_oe    = mem_oe;
  assign bus.mem_web   = mem_web;
  assign bus.mem_a     = mem_a;
  assign bus.mem_di    = mem_di;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences and
// a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW           = 14;
  localparam int STARVE_LIMIT = 3;
  localparam int DEPTH        = 1 << AW;
  localparam int NVEC         = 12;
  localparam int NRND         = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // SRAM behavioural model: one-cycle read latency, byte-masked writes.
  logic [31:0] sram [DEPTH];
  logic [31:0] sram_do;
  logic        sram_init;
  assign bus.mem_do = sram_do;

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = 32'(i);
    return 32'hA5C3_0000 ^ (v * 32'h0101_0101);
  endfunction

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
    end else if (bus.mem_cs) begin
      if (bus.mem_oe) sram_do <= sram[bus.mem_a];
      for (int b = 0; b < 4; b++) begin
        if (!bus.mem_web[b]) sram[bus.mem_a][b*8 +: 8] <= bus.mem_di[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic          im_req;
    logic [AW+1:0] im_addr;
    logic          dm_req;
    logic [3:0]    dm_web;
    logic [AW+1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          im_gnt;
    logic          dm_gnt;
    logic          im_stall;
    logic          dm_stall;
    logic          mem_cs;
    logic          mem_oe;
    logic [3:0]    mem_web;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_di;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.im_req   = 1'b0;
    bus.im_addr  = '0;
    bus.im_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_web   = 4'hF;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic add_vec(input int idx, input logic ir, input logic [AW+1:0] ia,
                         input logic dr, input logic [3:0] dw, input logic [AW+1:0] da,
                         input logic [31:0] wd, input logic ig, input logic dg,
                         input logic is, input logic ds, input logic cs, input logic oe,
                         input logic [3:0] web, input logic [AW-1:0] a, input logic [31:0] di);
    vecs[idx] = '{ir, ia, dr, dw, da, wd, ig, dg, is, ds, cs, oe, web, a, di};
  endtask

  // Transaction-level reference model state for the randomized run.
  int          denied;
  int          pend;
  logic [31:0] pend_data;
  logic [31:0] im_hold, dm_hold;
  logic [31:0] shadow [16];

  initial begin
    logic          e_im_gnt, e_dm_gnt, e_cs, e_oe, e_im_rv, e_dm_rv, e_rd;
    logic [3:0]    e_web;
    logic [AW-1:0] e_a;
    logic [31:0]   e_di;
    int            w;

    // ---- reset state, with requests pending during reset ----
    rst = 1'b1;
    idle_inputs();
    sram_init = 1'b1;
    step();
    sram_init = 1'b0;
    bus.im_req = 1'b1; bus.im_addr = 16'h0040;
    bus.dm_req = 1'b1; bus.dm_web = 4'h0; bus.dm_addr = 16'h0100; bus.dm_wdata = 32'h1234_5678;
    mid();
    $display("reset: im_gnt=%0b dm_gnt=%0b mem_cs=%0b", bus.im_gnt, bus.dm_gnt, bus.mem_cs);
    chk("rst.im_gnt", 32'(bus.im_gnt), 32'h0);
    chk("rst.dm_gnt", 32'(bus.dm_gnt), 32'h0);
    chk("rst.mem_cs", 32'(bus.mem_cs), 32'h0);
    chk("rst.mem_oe", 32'(bus.mem_oe), 32'h0);
    chk("rst.mem_web", 32'(bus.mem_web), 32'hF);
    chk("rst.mem_a", 32'(bus.mem_a), 32'h0);
    chk("rst.mem_di", bus.mem_di, 32'h0);
    chk("rst.im_rvalid", 32'(bus.im_rvalid), 32'h0);
    chk("rst.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("rst.im_rdata", bus.im_rdata, 32'h0);
    chk("rst.dm_rdata", bus.dm_rdata, 32'h0);
    step();
    idle_inputs();
    step();
    rst = 1'b0;

    // ---- vector table: issue logic and starvation across consecutive cycles ----
    add_vec(0,  0, 16'h0000, 0, 4'hF, 16'h0000, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 4'hF, 14'h000, 32'h0);
    add_vec(1,  1, 16'h0040, 0, 4'hF, 16'h0000, 32'h0,         1, 0, 0, 0, 1, 1, 4'hF, 14'h010, 32'h0);
    add_vec(2,  1, 16'h0040, 1, 4'h0, 16'h0100, 32'h1234_5678, 0, 1, 1, 0, 1, 0, 4'h0, 14'h040, 32'h1234_5678);
    add_vec(3,  1, 16'h0044, 0, 4'hF, 16'h0000, 32'hAAAA_5555, 1, 0, 0, 0, 1, 1, 4'hF, 14'h011, 32'hAAAA_5555);
    add_vec(4,  1, 16'h0080, 1, 4'hF, 16'h0200, 32'h0,         0, 1, 1, 0, 1, 1, 4'hF, 14'h080, 32'h0);
    add_vec(5,  1, 16'h0080, 1, 4'hF, 16'h0200, 32'h0,         0, 1, 1, 0, 1, 1, 4'hF, 14'h080, 32'h0);
    add_vec(6,  1, 16'h0080, 1, 4'hF, 16'h0200, 32'h0,         0, 1, 1, 0, 1, 1, 4'hF, 14'h080, 32'h0);
    add_vec(7,  1, 16'h0080, 1, 4'hF, 16'h0200, 32'h0,         1, 0, 0, 1, 1, 1, 4'hF, 14'h020, 32'h0);
    add_vec(8,  1, 16'h0080, 1, 4'hF, 16'h0200, 32'h0,         0, 1, 1, 0, 1, 1, 4'hF, 14'h080, 32'h0);
    add_vec(9,  0, 16'h0000, 1, 4'hA, 16'h0106, 32'hCAFE_0001, 0, 1, 0, 0, 1, 0, 4'hA, 14'h041, 32'hCAFE_0001);
    add_vec(10, 1, 16'h0003, 1, 4'hF, 16'h0204, 32'h0,         0, 1, 1, 0, 1, 1, 4'hF, 14'h081, 32'h0);
    add_vec(11, 0, 16'h0000, 0, 4'hF, 16'h0000, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 4'hF, 14'h000, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      bus.im_req = vecs[i].im_req;   bus.im_addr = vecs[i].im_addr;
      bus.dm_req = vecs[i].dm_req;   bus.dm_web  = vecs[i].dm_web;
      bus.dm_addr = vecs[i].dm_addr; bus.dm_wdata = vecs[i].dm_wdata;
      mid();
      $display("vec %0d: im_gnt=%0b dm_gnt=%0b mem_a=%h mem_web=%h", i, bus.im_gnt, bus.dm_gnt, bus.mem_a, bus.mem_web);
      chk($sformatf("vec%0d.im_gnt", i),   32'(bus.im_gnt),   32'(vecs[i].im_gnt));
      chk($sformatf("vec%0d.dm_gnt", i),   32'(bus.dm_gnt),   32'(vecs[i].dm_gnt));
      chk($sformatf("vec%0d.im_stall", i), 32'(bus.im_stall), 32'(vecs[i].im_stall));
      chk($sformatf("vec%0d.dm_stall", i), 32'(bus.dm_stall), 32'(vecs[i].dm_stall));
      chk($sformatf("vec%0d.mem_cs", i),   32'(bus.mem_cs),   32'(vecs[i].mem_cs));
      chk($sformatf("vec%0d.mem_oe", i),   32'(bus.mem_oe),   32'(vecs[i].mem_oe));
      chk($sformatf("vec%0d.mem_web", i),  32'(bus.mem_web),  32'(vecs[i].mem_web));
      chk($sformatf("vec%0d.mem_a", i),    32'(bus.mem_a),    32'(vecs[i].mem_a));
      chk($sformatf("vec%0d.mem_di", i),   bus.mem_di,        vecs[i].mem_di);
      step();
    end
    idle_inputs();

    // ---- directed: write then IM read with one-cycle return and hold ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.dm_req = 1'b1; bus.dm_web = 4'h0; bus.dm_addr = 16'h0040; bus.dm_wdata = 32'hDEAD_BEEF;
    mid();
    $display("seq write 0x0040: dm_gnt=%0b", bus.dm_gnt);
    chk("wr.dm_gnt", 32'(bus.dm_gnt), 32'h1);
    step();
    idle_inputs();
    bus.im_req = 1'b1; bus.im_addr = 16'h0040;
    mid();
    $display("seq im read 0x0040: im_gnt=%0b mem_a=%h", bus.im_gnt, bus.mem_a);
    chk("imrd.im_gnt", 32'(bus.im_gnt), 32'h1);
    chk("imrd.mem_a", 32'(bus.mem_a), 32'h010);
    chk("imrd.mem_oe", 32'(bus.mem_oe), 32'h1);
    step();
    idle_inputs();
    mid();
    $display("seq im return: im_rvalid=%0b im_rdata=%h", bus.im_rvalid, bus.im_rdata);
    chk("imret.im_rvalid", 32'(bus.im_rvalid), 32'h1);
    chk("imret.im_rdata", bus.im_rdata, 32'hDEAD_BEEF);
    chk("imret.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    step();
    mid();
    $display("seq im hold: im_rvalid=%0b im_rdata=%h", bus.im_rvalid, bus.im_rdata);
    chk("imhold.im_rvalid", 32'(bus.im_rvalid), 32'h0);
    chk("imhold.im_rdata", bus.im_rdata, 32'hDEAD_BEEF);

    // ---- directed: flushed IM read leaves im_rdata untouched ----
    step();
    bus.dm_req = 1'b1; bus.dm_web = 4'h0; bus.dm_addr = 16'h0044; bus.dm_wdata = 32'h0BAD_F00D;
    step();
    idle_inputs();
    bus.im_req = 1'b1; bus.im_addr = 16'h0044;
    mid();
    chk("flrd.im_gnt", 32'(bus.im_gnt), 32'h1);
    step();
    idle_inputs();
    bus.im_flush = 1'b1;
    mid();
    $display("seq flush: im_rvalid=%0b im_rdata=%h", bus.im_rvalid, bus.im_rdata);
    chk("flush.im_rvalid", 32'(bus.im_rvalid), 32'h0);
    chk("flush.im_rdata", bus.im_rdata, 32'hDEAD_BEEF);
    step();
    bus.im_flush = 1'b0;
    mid();
    chk("flush2.im_rdata", bus.im_rdata, 32'hDEAD_BEEF);

    // ---- directed: DM read return and hold ----
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0044;
    step();
    idle_inputs();
    mid();
    $display("seq dm return: dm_rvalid=%0b dm_rdata=%h", bus.dm_rvalid, bus.dm_rdata);
    chk("dmret.dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("dmret.dm_rdata", bus.dm_rdata, 32'h0BAD_F00D);
    chk("dmret.im_rvalid", 32'(bus.im_rvalid), 32'h0);
    step();
    mid();
    chk("dmhold.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("dmhold.dm_rdata", bus.dm_rdata, 32'h0BAD_F00D);

    // ---- directed: reset pulse discards a DM read in flight ----
    step();
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0040;
    mid();
    chk("rstrd.dm_gnt", 32'(bus.dm_gnt), 32'h1);
    step();
    idle_inputs();
    rst = 1'b1;
    mid();
    $display("seq reset in flight: dm_rvalid=%0b dm_rdata=%h", bus.dm_rvalid, bus.dm_rdata);
    chk("rstfl.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("rstfl.dm_rdata", bus.dm_rdata, 32'h0);
    chk("rstfl.im_rdata", bus.im_rdata, 32'h0);
    step();
    rst = 1'b0;
    mid();
    chk("rstrel.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("rstrel.im_rvalid", 32'(bus.im_rvalid), 32'h0);
    step();
    mid();
    chk("rstrel2.dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("rstrel2.dm_rdata", bus.dm_rdata, 32'h0);

    // ---- randomized run against the transaction-level model ----
    step();
    rst = 1'b1;
    sram_init = 1'b1;
    step();
    sram_init = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    denied = 0; pend = 0; pend_data = '0; im_hold = '0; dm_hold = '0;

    for (int c = 0; c < NRND; c++) begin
      bus.im_req   = ($urandom_range(0, 3) != 0);
      bus.im_addr  = 16'($urandom_range(0, 63));
      bus.im_flush = ($urandom_range(0, 4) == 0);
      bus.dm_req   = ($urandom_range(0, 1) != 0);
      bus.dm_web   = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      bus.dm_addr  = 16'($urandom_range(0, 63));
      bus.dm_wdata = $urandom;
      mid();

      e_im_gnt = bus.im_req && (!bus.dm_req || denied >= STARVE_LIMIT);
      e_dm_gnt = bus.dm_req && !e_im_gnt;
      e_rd     = (bus.dm_web == 4'hF);
      e_cs     = e_im_gnt || e_dm_gnt;
      e_oe     = e_im_gnt || (e_dm_gnt && e_rd);
      e_web    = e_dm_gnt ? bus.dm_web : 4'hF;
      e_a      = e_im_gnt ? AW'(bus.im_addr >> 2) : (e_dm_gnt ? AW'(bus.dm_addr >> 2) : '0);
      e_di     = e_cs ? bus.dm_wdata : 32'h0;
      e_im_rv  = (pend == 1) && !bus.im_flush;
      e_dm_rv  = (pend == 2);

      $display("rnd %0d: im_req=%0b dm_req=%0b dm_web=%h im_gnt=%0b dm_gnt=%0b mem_a=%h",
               c, bus.im_req, bus.dm_req, bus.dm_web, bus.im_gnt, bus.dm_gnt, bus.mem_a);
      chk($sformatf("rnd%0d.im_gnt", c),    32'(bus.im_gnt),    32'(e_im_gnt));
      chk($sformatf("rnd%0d.dm_gnt", c),    32'(bus.dm_gnt),    32'(e_dm_gnt));
      chk($sformatf("rnd%0d.im_stall", c),  32'(bus.im_stall),  32'(bus.im_req && !e_im_gnt));
      chk($sformatf("rnd%0d.dm_stall", c),  32'(bus.dm_stall),  32'(bus.dm_req && !e_dm_gnt));
      chk($sformatf("rnd%0d.mem_cs", c),    32'(bus.mem_cs),    32'(e_cs));
      chk($sformatf("rnd%0d.mem_oe", c),    32'(bus.mem_oe),    32'(e_oe));
      chk($sformatf("rnd%0d.mem_web", c),   32'(bus.mem_web),   32'(e_web));
      chk($sformatf("rnd%0d.mem_a", c),     32'(bus.mem_a),     32'(e_a));
      chk($sformatf("rnd%0d.mem_di", c),    bus.mem_di,         e_di);
      chk($sformatf("rnd%0d.im_rvalid", c), 32'(bus.im_rvalid), 32'(e_im_rv));
      chk($sformatf("rnd%0d.dm_rvalid", c), 32'(bus.dm_rvalid), 32'(e_dm_rv));
      chk($sformatf("rnd%0d.im_rdata", c),  bus.im_rdata,       e_im_rv ? pend_data : im_hold);
      chk($sformatf("rnd%0d.dm_rdata", c),  bus.dm_rdata,       e_dm_rv ? pend_data : dm_hold);

      if (e_im_rv) im_hold = pend_data;
      if (e_dm_rv) dm_hold = pend_data;
      pend = 0;
      if (e_im_gnt) begin
        pend      = 1;
        pend_data = shadow[bus.im_addr[5:2]];
      end else if (e_dm_gnt) begin
        w = int'(bus.dm_addr[5:2]);
        if (e_rd) begin
          pend      = 2;
          pend_data = shadow[w];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (!bus.dm_web[b]) shadow[w][b*8 +: 8] = bus.dm_wdata[b*8 +: 8];
          end
        end
      end
      denied = (bus.im_req && !e_im_gnt) ? denied + 1 : 0;
      step();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, number of consecutive denied IM request cycles before IM gets priority.
REQ-002 Parameter: AW, default 14, word-address width of the shared SRAM port.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 im_req  input  1  instruction fetch request, read only.
REQ-007 im_addr  input  AW+2  IM byte address; bits [1:0] ignored.
REQ-008 im_flush  input  1  branch/JAL flush; cancels IM read data due this cycle.
REQ-009 dm_req  input  1  data access request.
REQ-010 dm_web  input  4  active-low byte write enables; 4'hF means read.
REQ-011 dm_addr  input  AW+2  DM byte address; bits [1:0] ignored.
REQ-012 dm_wdata  input  32  write data.
REQ-013 im_gnt / dm_gnt  output  1 each  access issued to SRAM this cycle.
REQ-014 im_stall / dm_stall  output  1 each  request pending but not granted this cycle.
REQ-015 im_rvalid / dm_rvalid  output  1 each  read data returned this cycle.
REQ-016 im_rdata / dm_rdata  output  32 each  read data; holds last returned value.
REQ-017 mem_cs, mem_oe  output  1 each  SRAM chip select, output enable.
REQ-018 mem_web  output  4  SRAM byte write enables, active-low.
REQ-019 mem_a  output  AW  SRAM word address.
REQ-020 mem_di  output  32  SRAM write data.
REQ-021 mem_do  input  32  SRAM read data, valid one cycle after a read issue.

Function
REQ-022 At most one access shall be issued per cycle; issue is combinational in the grant cycle.
REQ-023 Priority: DM over IM, unless starve_cnt == STARVE_LIMIT and im_req=1, in which case IM shall be granted.
REQ-024 starve_cnt (2 bits) shall increment, saturating at STARVE_LIMIT, on each cycle with im_req=1 and im_gnt=0, and shall clear on im_gnt=1 or im_req=0.
REQ-025 X_stall shall equal X_req AND NOT X_gnt for X in {im, dm}.
REQ-026 On grant: mem_cs=1; mem_a=addr[AW+1:2] of the winner; mem_web = dm_web for DM, 4'hF for IM; mem_oe=1 only for reads; mem_di=dm_wdata.
REQ-027 With no grant: mem_cs=0, mem_oe=0, mem_web=4'hF, mem_a=0, mem_di=0.
REQ-028 FSM states IDLE, RD_IM, RD_DM record the read in flight; next state is RD_IM on IM grant, RD_DM on DM read grant, IDLE otherwise (including DM write).
REQ-029 A new grant shall be allowed in any state (back-to-back reads at one per cycle).
REQ-030 In RD_IM: im_rvalid=1 unless im_flush=1; on valid, im_rdata=mem_do and the value is also captured into the hold register.
REQ-031 In RD_DM: dm_rvalid=1; on valid, dm_rdata=mem_do and the value is also captured into the hold register.
REQ-032 When rvalid=0, X_rdata shall output its hold register.
REQ-033 A flushed IM read shall not update im_rdata.
REQ-034 Writes have no response; data is committed in the grant cycle.
REQ-035 On simultaneous im_req and dm write without starvation: dm granted, im_stall=1.

Reset
REQ-036 While rst=1: state=IDLE, starve_cnt=0, hold registers=0, all gnt/rvalid=0, SRAM port at idle values; deassertion starts in IDLE.
REQ-037 Reset asserted during a read in flight shall discard it; no rvalid after reset release.

Verification
REQ-038 Reset: rst=1 -> all outputs idle, im_rdata=dm_rdata=0, mem_web=4'hF.
REQ-039 IM read 0x0040, mem_do=0xDEADBEEF -> cycle N: im_gnt=1, mem_a=0x010; cycle N+1: im_rvalid=1, im_rdata=0xDEADBEEF, which is held afterwards.
REQ-040 im_req + dm write (dm_web=4'h0, addr 0x0100, data 0x12345678) same cycle -> dm_gnt=1, mem_web=4'h0, mem_a=0x040, im_stall=1; next cycle im_gnt=1.
REQ-041 dm_req held 4 cycles with im_req -> cycles 1-3 dm granted; cycle 4 im_gnt=1, dm_stall=1, starve_cnt returns to 0.
REQ-042 IM read granted, im_flush=1 the next cycle -> im_rvalid=0 and im_rdata keeps its previous value.
REQ-043 Reset pulse in the cycle after a DM read grant -> dm_rvalid stays 0 and state=IDLE after release.
